// File: rtl/body_rate_controller_pkg.sv
// Shared constants, state encoding and saturation helpers for the body-rate loop.
// All rates are signed Q12.4 deg/s.
// Build option: define BODY_RATE_INTEGRAL_EN to add the per-axis integrator.
package body_rate_controller_pkg;

  localparam int RATE_BIT_WIDTH = 16;
  localparam int KI_SHIFT       = 4;

  localparam logic signed [15:0] KP_YAW        = 16'sh0010;  // 1.0
  localparam logic signed [15:0] KP_PITCH      = 16'sh0018;  // 1.5
  localparam logic signed [15:0] KP_ROLL       = 16'sh0018;  // 1.5
  localparam logic signed [15:0] I_LIMIT       = 16'sh0320;  // +/-50.0
  localparam logic signed [15:0] CMD_MAX       = 16'sh0640;  // +/-100.0
  localparam logic signed [15:0] THROTTLE_MAX  = 16'sh0fa0;  // 250.0
  localparam logic signed [15:0] THROTTLE_IDLE = 16'sh0100;  // 16.0

  // One-hot controller states
  typedef enum logic [5:0] {
    S_WAIT     = 6'b000001,
    S_ERROR    = 6'b000010,
    S_SCALE    = 6'b000100,
    S_ACCUM    = 6'b001000,
    S_LIMIT    = 6'b010000,
    S_COMPLETE = 6'b100000
  } state_t;

  function automatic logic signed [31:0] sx32(input logic signed [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic signed [15:0] clamp16(input logic signed [31:0] v,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
    logic signed [31:0] r;
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    return r[15:0];
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    return clamp16(v, -32'sd32768, 32'sd32767);
  endfunction

endpackage

// File: rtl/body_rate_controller_rate_axis_pid.sv
// One body axis of the rate loop: error, P scaling, optional integrator, command clamp.
// Each stage register advances only on its enable from the top-level FSM.
// Build option: BODY_RATE_INTEGRAL_EN adds the clamped integrator; otherwise pure P.
module rate_axis_pid
  import body_rate_controller_pkg::*;
#(
  parameter logic signed [15:0] KP = 16'sh0010
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_en_err,
  input  logic                              i_en_scale,
  input  logic                              i_en_accum,
  input  logic                              i_en_limit,
  input  logic                              i_ground,
  input  logic signed [RATE_BIT_WIDTH-1:0] i_target,
  input  logic signed [RATE_BIT_WIDTH-1:0] i_actual,
  output logic signed [RATE_BIT_WIDTH-1:0] o_cmd
);

  logic signed [15:0] r_err;
  logic signed [15:0] r_p;
  logic signed [16:0] r_sum;
  logic signed [15:0] r_cmd;

  logic signed [31:0] w_diff;
  logic signed [31:0] w_prod;
  logic signed [31:0] w_scaled;
  logic signed [15:0] w_integ_next;
  logic signed [16:0] w_sum;

  assign w_diff   = sx32(i_target) - sx32(i_actual);
  assign w_prod   = sx32(r_err) * sx32(KP);
  assign w_scaled = w_prod >>> 4;

`ifdef BODY_RATE_INTEGRAL_EN
  logic signed [15:0] r_integ;
  logic signed [15:0] w_inc;
  logic signed [31:0] w_integ_raw;

  assign w_inc        = r_err >>> KI_SHIFT;
  assign w_integ_raw  = sx32(r_integ) + sx32(w_inc);
  // On the ground the integrator is held at zero so it cannot wind up
  assign w_integ_next = i_ground ? 16'sd0
                                 : clamp16(w_integ_raw, -sx32(I_LIMIT), sx32(I_LIMIT));

  // Integrator steps once per transaction, in the ACCUM cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           r_integ <= '0;
    else if (i_en_accum) r_integ <= w_integ_next;
  end
`else
  logic w_unused_ground;
  assign w_unused_ground = i_ground;
  assign w_integ_next    = '0;
`endif

  // p is at most 0x7FFF and integ at most I_LIMIT, so 17 bits cannot overflow
  assign w_sum = {r_p[15], r_p} + {w_integ_next[15], w_integ_next};

  // Stage registers: error, scaled P, sum, clamped command
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= '0;
      r_p   <= '0;
      r_sum <= '0;
      r_cmd <= '0;
    end else begin
      if (i_en_err)   r_err <= sat16(w_diff);
      if (i_en_scale) r_p   <= sat16(w_scaled);
      if (i_en_accum) r_sum <= w_sum;
      if (i_en_limit) r_cmd <= clamp16({{15{r_sum[16]}}, r_sum}, -sx32(CMD_MAX), sx32(CMD_MAX));
    end
  end

  assign o_cmd = r_cmd;

endmodule

// File: rtl/body_rate_controller.sv
// Body-frame rate controller: captures targets/gyro rates on a start request,
// runs three axis pipelines in lock-step and publishes clamped commands.
// Handshake: start_signal is a level request sampled only in WAIT (ignored elsewhere,
// never queued); complete_signal is a one-cycle valid for the command outputs, which
// hold until the next transaction; active_signal marks the four compute cycles.
// Build option: BODY_RATE_INTEGRAL_EN enables the per-axis integrators.
module body_rate_controller
  import body_rate_controller_pkg::*;
(
  input  logic                              us_clk,
  input  logic                              reset,
  input  logic                              start_signal,
  input  logic signed [RATE_BIT_WIDTH-1:0] throttle_rate_in,
  input  logic signed [RATE_BIT_WIDTH-1:0] yaw_rate_target,
  input  logic signed [RATE_BIT_WIDTH-1:0] pitch_rate_target,
  input  logic signed [RATE_BIT_WIDTH-1:0] roll_rate_target,
  input  logic signed [RATE_BIT_WIDTH-1:0] yaw_rate_actual,
  input  logic signed [RATE_BIT_WIDTH-1:0] pitch_rate_actual,
  input  logic signed [RATE_BIT_WIDTH-1:0] roll_rate_actual,
  output logic signed [RATE_BIT_WIDTH-1:0] throttle_cmd,
  output logic signed [RATE_BIT_WIDTH-1:0] yaw_cmd,
  output logic signed [RATE_BIT_WIDTH-1:0] pitch_cmd,
  output logic signed [RATE_BIT_WIDTH-1:0] roll_cmd,
  output logic                              active_signal,
  output logic                              complete_signal,
  output state_t                            dbg_state
);

  state_t r_state;
  state_t w_next;
  logic   w_capture, w_en_err, w_en_scale, w_en_accum, w_en_limit;
  logic   w_active, w_complete, w_ground;

  logic signed [15:0] r_thr, r_thr_cmd;
  logic signed [15:0] r_yaw_tgt, r_pitch_tgt, r_roll_tgt;
  logic signed [15:0] r_yaw_act, r_pitch_act, r_roll_act;

  // State register
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) r_state <= S_WAIT;
    else       r_state <= w_next;
  end

  // Next state and per-state stage enables; unknown encodings fall back to WAIT
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_en_err   = 1'b0;
    w_en_scale = 1'b0;
    w_en_accum = 1'b0;
    w_en_limit = 1'b0;
    w_active   = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (start_signal) begin
          w_capture = 1'b1;
          w_next    = S_ERROR;
        end
      end
      S_ERROR:    begin w_en_err   = 1'b1; w_active = 1'b1; w_next = S_SCALE;    end
      S_SCALE:    begin w_en_scale = 1'b1; w_active = 1'b1; w_next = S_ACCUM;    end
      S_ACCUM:    begin w_en_accum = 1'b1; w_active = 1'b1; w_next = S_LIMIT;    end
      S_LIMIT:    begin w_en_limit = 1'b1; w_active = 1'b1; w_next = S_COMPLETE; end
      S_COMPLETE: begin w_complete = 1'b1; w_next = S_WAIT; end
      default:    w_next = S_WAIT;
    endcase
  end

  // Input capture in WAIT, throttle command published on LIMIT exit
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      r_thr       <= '0;
      r_yaw_tgt   <= '0;
      r_pitch_tgt <= '0;
      r_roll_tgt  <= '0;
      r_yaw_act   <= '0;
      r_pitch_act <= '0;
      r_roll_act  <= '0;
      r_thr_cmd   <= '0;
    end else begin
      if (w_capture) begin
        r_thr       <= throttle_rate_in;
        r_yaw_tgt   <= yaw_rate_target;
        r_pitch_tgt <= pitch_rate_target;
        r_roll_tgt  <= roll_rate_target;
        r_yaw_act   <= yaw_rate_actual;
        r_pitch_act <= pitch_rate_actual;
        r_roll_act  <= roll_rate_actual;
      end
      if (w_en_limit) r_thr_cmd <= clamp16(sx32(r_thr), 32'sd0, sx32(THROTTLE_MAX));
    end
  end

  assign w_ground = (r_thr < THROTTLE_IDLE);

  rate_axis_pid #(.KP(KP_YAW)) u_yaw (
    .i_clk(us_clk), .i_rst(reset), .i_en_err(w_en_err), .i_en_scale(w_en_scale),
    .i_en_accum(w_en_accum), .i_en_limit(w_en_limit), .i_ground(w_ground),
    .i_target(r_yaw_tgt), .i_actual(r_yaw_act), .o_cmd(yaw_cmd)
  );

  rate_axis_pid #(.KP(KP_PITCH)) u_pitch (
    .i_clk(us_clk), .i_rst(reset), .i_en_err(w_en_err), .i_en_scale(w_en_scale),
    .i_en_accum(w_en_accum), .i_en_limit(w_en_limit), .i_ground(w_ground),
    .i_target(r_pitch_tgt), .i_actual(r_pitch_act), .o_cmd(pitch_cmd)
  );

  rate_axis_pid #(.KP(KP_ROLL)) u_roll (
    .i_clk(us_clk), .i_rst(reset), .i_en_err(w_en_err), .i_en_scale(w_en_scale),
    .i_en_accum(w_en_accum), .i_en_limit(w_en_limit), .i_ground(w_ground),
    .i_target(r_roll_tgt), .i_actual(r_roll_act), .o_cmd(roll_cmd)
  );

  assign throttle_cmd    = r_thr_cmd;
  assign active_signal   = w_active;
  assign complete_signal = w_complete;
  assign dbg_state       = r_state;

endmodule
